addtree_pipe: RTL and testbench
===============================

// Module: addtree_pipe
// PURPOSE
//   Parametrised pipelined adder tree: sums N lanes of W-bit operands to one full-precision result.
//   One register level per tree level. Valid/ready flow control with per-stage bubble collapsing.
//   Generalises the fixed 4x64 tree to any power-of-two lane count, adds signed mode and backpressure.
//   Sits between operand producers and any accumulator/consumer that may stall.
// PARAMETERS
//   W       64  operand width per lane, >=1
//   N       4   lane count, power of two, >=2
//   SIGNED  0   1: lanes are two's complement, sign-extended at each level; 0: zero-extended
//   L       $clog2(N)  (localparam) tree depth = pipeline latency in cycles
//   OW      W+L        (localparam) output width
// PORTS
//   clk        in   1     clock, rising edge
//   reset      in   1     asynchronous, active-low reset
//   in_valid   in   1     in_data holds a valid operand set
//   in_ready   out  1     tree accepts in_data this cycle
//   in_data    in   N*W   lane i at in_data[i*W +: W]
//   out_valid  out  1     out_sum valid
//   out_ready  in   1     consumer accepts out_sum this cycle
//   out_sum    out  OW    sum of all N lanes, full precision
// BEHAVIOUR
//   - Reset (reset==0, async): every stage valid bit=0, every partial-sum reg=0.
//     out_valid=0, out_sum=0 immediately. In-flight data is discarded.
//     First load possible on the first rising edge with reset==1.
//   - Stage l (l=0..L-1): holds N>>(l+1) partial sums of width W+l+1, plus valid bit v[l].
//     p[l][j] = ext(p[l-1][2j]) + ext(p[l-1][2j+1]); stage -1 is the in_data lanes.
//     ext = sign-extend if SIGNED else zero-extend, by 1 bit. No overflow is possible.
//   - Advance enables: en[L-1] = !v[L-1] | out_ready; en[l] = !v[l] | en[l+1].
//     On en[l]: v[l] <= v[l-1] (v[-1]=in_valid) and data regs load. Otherwise hold.
//   - in_ready = en[0] (combinational from out_ready and the valid bits only; never from in_valid).
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - out_valid = v[L-1]; out_sum = p[L-1][0].
//     Unconstrained latency L cycles from input transfer to out_valid.
//   - Bubble collapse: an empty stage always loads even while downstream is stalled.
//     A full pipe under stall absorbs no new data.
//   - Stall: while out_valid & !out_ready, out_sum and out_valid hold stable.
//     No valid stage is overwritten.
//   - Simultaneous in/out transfer on a full pipe: throughput 1 result/cycle, no bubble inserted.
//   - Data regs may load with v=0 (don't-care contents); verification checks out_sum only when out_valid=1.
//   - Ordering: results emerge in input-transfer order. No drop, no duplication.
// TESTING
//   1 Reset: reset=0 mid-stream with a full pipe -> out_valid=0, out_sum=0 same cycle.
//     After release, first result appears only for post-reset inputs.
//   2 Unsigned N=4 W=64 SIGNED=0: lanes all 64'hFFFF_FFFF_FFFF_FFFF, out_ready=1
//     -> 2 cycles later out_sum=66'h3_FFFF_FFFF_FFFF_FFFC.
//   3 Signed N=8 W=8 SIGNED=1: lanes {-128,-128,-128,-128,-128,-128,-128,-128} -> out_sum=11'h400 (-1024).
//     Lanes {127,-1,0,0,0,0,0,5} -> 11'd131.
//   4 Backpressure N=4: stream 1,2,3,... (lane0=k, others 0), out_ready=0 for 5 cycles
//     -> in_ready drops after 2 accepts; out_sum=1 held stable; on release 1,2,3,... in order, none lost.
//   5 Full throughput: in_valid=1 and out_ready=1 continuously for 100 vectors
//     -> 100 results, one per cycle after L-cycle fill, all matching the reference model.
//   6 Random valid/ready toggling, 10k vectors, N=16 W=13 both SIGNED values
//     -> scoreboard matches the model in order; in_ready never depends on in_valid.

Source files
------------

// File: rtl/addtree_pipe_if.sv
// Operand/result stream bundle for the pipelined adder tree.
// master drives operands and sink ready; slave is the tree.
interface addtree_pipe_if #(
  parameter int W = 64,
  parameter int N = 4
);
  localparam int OW = W + $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/addtree_pipe.sv
// Pipelined N-lane adder tree, one register level per tree level.
// Valid/ready flow control with per-stage bubble collapsing.
module addtree_pipe #(
  parameter int W      = 64,
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input logic           clk,
  input logic           reset,
  addtree_pipe_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int OW = W + L;
  localparam bit SX = (SIGNED != 0);

  // bit offset of level l inside the packed tree vector
  function automatic int lvl_base(int l);
    int b;
    b = 0;
    for (int k = 0; k < l; k++)
      b += (N >> (k + 1)) * (W + k + 1);
    return b;
  endfunction

  localparam int TB = lvl_base(L);

  logic [TB-1:0] tree;
  logic [L-1:0]  v;
  logic [L-1:0]  vn;
  logic [L-1:0]  en;

  // a stage advances unless it and all later stages are full
  // while the sink stalls
  always_comb begin
    logic full;
    full = 1'b1;
    en   = '0;
    for (int i = L - 1; i >= 0; i--) begin
      full  = full & v[i];
      en[i] = bus.out_ready | !full;
    end
  end

  // valid bit each stage would take from its upstream neighbour
  always_comb begin
    vn    = '0;
    vn[0] = bus.in_valid;
    for (int i = 1; i < L; i++)
      vn[i] = v[i - 1];
  end

  // valid bits shift forward only where the stage is enabled
  always_ff @(posedge clk or negedge reset)
    if (!reset) v <= '0;
    else        v <= (en & vn) | (~en & v);

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NS = N >> (l + 1);
    localparam int LW = W + l + 1;
    localparam int BO = lvl_base(l);

    logic [NS*LW-1:0] psum;
    logic [NS*LW-1:0] q;

    for (genvar j = 0; j < NS; j++) begin : g_add
      logic [LW-2:0] a;
      logic [LW-2:0] b;

      if (l == 0) begin : g_src
        assign a = bus.in_data[2*j*W +: W];
        assign b = bus.in_data[(2*j+1)*W +: W];
      end else begin : g_src
        localparam int PB = lvl_base(l - 1);
        assign a = tree[PB + 2*j*(LW-1) +: LW-1];
        assign b = tree[PB + (2*j+1)*(LW-1) +: LW-1];
      end

      assign psum[j*LW +: LW] =
        {SX & a[LW-2], a} + {SX & b[LW-2], b};
    end

    // partial sums load alongside the valid bit of this level
    always_ff @(posedge clk or negedge reset)
      if (!reset)     q <= '0;
      else if (en[l]) q <= psum;

    assign tree[BO +: NS*LW] = q;
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v[L-1];
  assign bus.out_sum   = tree[TB-OW +: OW];
endmodule

// File: tb/tb_addtree_pipe.sv
// Bench for addtree_pipe: directed and random streams
// checked against lane sums computed with plain arithmetic.
module tb_addtree_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  addtree_pipe_if #(.W(64), .N(4))  ba ();
  addtree_pipe_if #(.W(8),  .N(8))  bb ();
  addtree_pipe_if #(.W(13), .N(16)) bc ();
  addtree_pipe_if #(.W(13), .N(16)) bd ();

  addtree_pipe #(.W(64), .N(4), .SIGNED(0)) u_a (
    .clk(clk), .reset(reset), .bus(ba));
  addtree_pipe #(.W(8), .N(8), .SIGNED(1)) u_b (
    .clk(clk), .reset(reset), .bus(bb));
  addtree_pipe #(.W(13), .N(16), .SIGNED(0)) u_c (
    .clk(clk), .reset(reset), .bus(bc));
  addtree_pipe #(.W(13), .N(16), .SIGNED(1)) u_d (
    .clk(clk), .reset(reset), .bus(bd));

  int nvec = 0;
  int nerr = 0;
  int nchk = 0;

  logic [65:0] qa[$];
  logic [10:0] qb[$];
  logic [16:0] qc[$];
  logic [16:0] qd[$];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] sum4(logic [255:0] d);
    logic [65:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      s = s + {2'b00, d[i*64 +: 64]};
    return s;
  endfunction

  function automatic logic [10:0] sum8s(logic [63:0] d);
    int s;
    logic [7:0] x;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      x = d[i*8 +: 8];
      s += int'($signed(x));
    end
    return s[10:0];
  endfunction

  function automatic logic [16:0] sum16(logic [207:0] d, bit sg);
    longint s;
    logic [12:0] x;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      x = d[i*13 +: 13];
      if (sg) s += longint'($signed(x));
      else    s += longint'(x);
    end
    return s[16:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [207:0] rnd208();
    logic [207:0] r;
    for (int i = 0; i < 16; i++)
      case ($urandom_range(0, 7))
        0:       r[i*13 +: 13] = 13'h1000;
        1:       r[i*13 +: 13] = 13'h1fff;
        default: r[i*13 +: 13] = 13'($urandom);
      endcase
    return r;
  endfunction

  task automatic step_a(input bit iv, input logic [255:0] d,
                        input bit ordy, output bit acc,
                        output bit got);
    logic [65:0] e;
    @(negedge clk);
    ba.in_valid  = iv;
    ba.in_data   = d;
    ba.out_ready = ordy;
    #1;
    acc = iv && ba.in_ready;
    got = ba.out_valid && ordy;
    if (got) begin
      if (qa.size() == 0) chk("a_spurious", qa.size(), 1);
      else begin
        e = qa.pop_front();
        chk("a_sum", ba.out_sum, e);
      end
    end
    if (acc) begin
      qa.push_back(sum4(d));
      nvec++;
    end
  endtask

  task automatic step_b(input bit iv, input logic [63:0] d,
                        input bit ordy);
    logic [10:0] e;
    @(negedge clk);
    bb.in_valid  = iv;
    bb.in_data   = d;
    bb.out_ready = ordy;
    #1;
    if (bb.out_valid && ordy) begin
      if (qb.size() == 0) chk("b_spurious", qb.size(), 1);
      else begin
        e = qb.pop_front();
        chk("b_sum", bb.out_sum, e);
      end
    end
    if (iv && bb.in_ready) begin
      qb.push_back(sum8s(d));
      nvec++;
    end
  endtask

  task automatic step_cd(input bit iv, input logic [207:0] d,
                         input bit ordy, output bit acc);
    logic r0;
    logic [16:0] e;
    @(negedge clk);
    bc.in_valid  = 1'b0;
    bd.in_valid  = 1'b0;
    bc.in_data   = d;
    bd.in_data   = d;
    bc.out_ready = ordy;
    bd.out_ready = ordy;
    #1;
    r0 = bc.in_ready;
    bc.in_valid = iv;
    bd.in_valid = iv;
    #1;
    chk("cd_ready_indep", bc.in_ready, r0);
    acc = iv && bc.in_ready;
    if (bc.out_valid && ordy) begin
      if (qc.size() == 0) chk("c_spurious", qc.size(), 1);
      else begin
        e = qc.pop_front();
        chk("c_sum", bc.out_sum, e);
      end
    end
    if (bd.out_valid && ordy) begin
      if (qd.size() == 0) chk("d_spurious", qd.size(), 1);
      else begin
        e = qd.pop_front();
        chk("d_sum", bd.out_sum, e);
      end
    end
    if (acc) begin
      qc.push_back(sum16(d, 1'b0));
      nvec++;
    end
    if (iv && bd.in_ready) qd.push_back(sum16(d, 1'b1));
  endtask

  initial begin
    bit acc, got;
    int k, nacc, nout, nst, ncd;
    logic [255:0] d;

    ba.in_valid = 0; ba.in_data = '0; ba.out_ready = 0;
    bb.in_valid = 0; bb.in_data = '0; bb.out_ready = 0;
    bc.in_valid = 0; bc.in_data = '0; bc.out_ready = 0;
    bd.in_valid = 0; bd.in_data = '0; bd.out_ready = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", ba.out_valid, 0);
    chk("rst_sum", ba.out_sum, 0);
    chk("rst_ready", ba.in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // reset with a full pipe
    d = {4{64'd7}};
    repeat (3) step_a(1, d, 0, acc, got);
    chk("t1_full", ba.in_ready, 0);
    chk("t1_fullv", ba.out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_rst_valid", ba.out_valid, 0);
    chk("t1_rst_sum", ba.out_sum, 0);
    qa.delete();
    ba.in_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    d = {64'd4, 64'd3, 64'd2, 64'd1};
    step_a(1, d, 1, acc, got);
    chk("t1_acc", acc, 1);
    nout = 0;
    repeat (6) begin
      step_a(0, '0, 1, acc, got);
      if (got) nout++;
    end
    chk("t1_nout", nout, 1);

    // all-ones lanes, latency two
    d = {4{64'hffff_ffff_ffff_ffff}};
    step_a(1, d, 1, acc, got);
    chk("t2_acc", acc, 1);
    step_a(0, '0, 1, acc, got);
    chk("t2_lat1", ba.out_valid, 0);
    step_a(0, '0, 1, acc, got);
    chk("t2_valid", ba.out_valid, 1);
    chk("t2_sum", ba.out_sum, 66'h3_ffff_ffff_ffff_fffc);

    // signed eight-lane corner values
    step_b(1, {8{8'h80}}, 1);
    step_b(1, {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hff, 8'h7f}, 1);
    step_b(0, '0, 1);
    step_b(0, '0, 1);
    chk("t3_valid0", bb.out_valid, 1);
    chk("t3_min", bb.out_sum, 11'h400);
    step_b(0, '0, 1);
    chk("t3_valid1", bb.out_valid, 1);
    chk("t3_mix", bb.out_sum, 11'd131);
    repeat (2) step_b(0, '0, 1);
    chk("t3_drain", qb.size(), 0);

    // backpressure
    k = 1;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      step_a(1, 256'(k), 0, acc, got);
      if (acc) begin k++; nacc++; end
      if (i >= 2) begin
        chk("t4_ready", ba.in_ready, 0);
        chk("t4_hold_v", ba.out_valid, 1);
        chk("t4_hold_sum", ba.out_sum, 1);
      end
    end
    chk("t4_accepts", nacc, 2);
    for (int i = 0; i < 40 && k <= 10; i++) begin
      step_a(1, 256'(k), 1, acc, got);
      if (acc) k++;
    end
    repeat (6) step_a(0, '0, 1, acc, got);
    chk("t4_drain", qa.size(), 0);

    // full throughput
    nout = 0;
    nst = 0;
    for (int i = 0; i < 102; i++) begin
      step_a(i < 100, rnd256(), 1, acc, got);
      if (i < 100 && !acc) nst++;
      if (got) nout++;
    end
    chk("t5_stalls", nst, 0);
    chk("t5_outs", nout, 100);

    // random valid/ready toggling, both signedness modes
    ncd = 0;
    for (int c = 0; c < 40000 && ncd < 10000; c++) begin
      step_cd($urandom_range(0, 9) < 7, rnd208(),
              $urandom_range(0, 3) != 0, acc);
      if (acc) ncd++;
    end
    chk("t6_count", ncd, 10000);
    repeat (40) step_cd(0, '0, 1, acc);
    chk("t6_drain_c", qc.size(), 0);
    chk("t6_drain_d", qd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
